serial_bus_cmd_scheduler: RTL and testbench

Queued successor to the single-shot serial-bus event handler. Accepts write/read commands into a CMD_DEPTH-entry FIFO and issues them one at a time to the serial bus master via instruction/slave/address/data/burst outputs. Streams each received read byte out. Enforces a per-transaction timeout with error reporting. Sits between the host/user logic and the serial bus master in the top module.

---
 rtl/serial_bus_cmd_scheduler.sv | 108 ++++++++++
 tb/tb_serial_bus_cmd_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_cmd_scheduler.sv
// serial_bus_cmd_scheduler: queues write/read commands and issues them one at a time to the serial bus master
module serial_bus_cmd_scheduler #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [SLAVE_LEN-1:0]               cmd_slave,
  input  logic [ADDR_LEN-1:0]                cmd_addr,
  input  logic [DATA_LEN-1:0]                cmd_data,
  input  logic [BURST_LEN-1:0]               cmd_burst,
  input  logic                               flush,
  input  logic                               err_clr,
  input  logic                               trans_done,
  input  logic                               new_rx,
  input  logic [DATA_LEN-1:0]                data_in,
  output logic [1:0]                         instruction,
  output logic [SLAVE_LEN-1:0]               slave_select,
  output logic [ADDR_LEN-1:0]                address,
  output logic [DATA_LEN-1:0]                data_out,
  output logic [BURST_LEN-1:0]               burst_num,
  output logic                               rx_valid,
  output logic [DATA_LEN-1:0]                rx_data,
  output logic                               done,
  output logic                               done_err,
  output logic                               err,
  output logic [$clog2(CMD_DEPTH+1)-1:0]     level,
  output logic                               busy
);
  localparam int LW = $clog2(CMD_DEPTH+1);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 1 + SLAVE_LEN + ADDR_LEN + DATA_LEN + BURST_LEN;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;
  state_t state;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic push, pop, timeout;
  logic h_write;
  logic [SLAVE_LEN-1:0] h_slave;
  logic [ADDR_LEN-1:0] h_addr;
  logic [DATA_LEN-1:0] h_data;
  logic [BURST_LEN-1:0] h_burst;
  assign cmd_ready = level != LW'(CMD_DEPTH);
  assign push = cmd_valid && cmd_ready && !flush;
  assign pop = state == IDLE && level != '0 && !flush;
  // trans_done on the last allowed cycle counts as a normal completion
  assign timeout = TIMEOUT != 0 && state != IDLE && timer == TW'(TIMEOUT - 1) && !trans_done;
  assign busy = state != IDLE || level != '0;
  assign {h_write, h_slave, h_addr, h_data, h_burst} = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_write, cmd_slave, cmd_addr, cmd_data, cmd_burst};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      timer <= '0;
      instruction <= 2'b00;
      slave_select <= SLAVE_LEN'(1);
      address <= '0;
      data_out <= '0;
      burst_num <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      done <= 1'b0;
      done_err <= 1'b0;
      err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done <= 1'b0;
      done_err <= 1'b0;
      wr_ptr <= flush ? '0 : push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= flush ? '0 : pop ? rd_ptr + PW'(1) : rd_ptr;
      level <= flush ? '0 : level + LW'(push) - LW'(pop);
      err <= timeout ? 1'b1 : err_clr ? 1'b0 : err;
      if (state == IDLE) begin
        if (pop) begin
          state <= h_write ? WAIT_WR : WAIT_RD;
          instruction <= h_write ? 2'b10 : 2'b11;
          {slave_select, address, data_out, burst_num} <= {h_slave, h_addr, h_data, h_burst};
          timer <= '0;
        end
      end else begin
        timer <= timer + TW'(1);
        if (state == WAIT_RD && new_rx) begin
          rx_data <= data_in;
          rx_valid <= 1'b1;
        end
        if (trans_done || timeout) begin
          state <= IDLE;
          instruction <= 2'b00;
          done <= 1'b1;
          done_err <= timeout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_bus_cmd_scheduler.sv
// tb_serial_bus_cmd_scheduler: scoreboard bench; a second instance with TIMEOUT=16 covers the abort path
module tb_serial_bus_cmd_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, flush = 1'b0, err_clr = 1'b0, trans_done = 1'b0, new_rx = 1'b0;
  logic [1:0] cmd_slave = '0;
  logic [11:0] cmd_addr = '0, cmd_burst = '0;
  logic [7:0] cmd_data = '0, data_in = '0;
  logic cmd_ready, rx_valid, done, done_err, err, busy;
  logic [1:0] instruction, slave_select;
  logic [11:0] address, burst_num;
  logic [7:0] data_out, rx_data;
  logic [2:0] level;
  logic t_cmd_ready, t_rx_valid, t_done, t_done_err, t_err, t_busy;
  logic [1:0] t_instruction, t_slave_select;
  logic [11:0] t_address, t_burst_num;
  logic [7:0] t_data_out, t_rx_data;
  logic [2:0] t_level;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [35:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [1:0] prev_instr = 2'b00;

  always #5 clk = ~clk;

  serial_bus_cmd_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_burst(cmd_burst),
    .flush(flush), .err_clr(err_clr), .trans_done(trans_done), .new_rx(new_rx), .data_in(data_in),
    .instruction(instruction), .slave_select(slave_select), .address(address), .data_out(data_out),
    .burst_num(burst_num), .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .done_err(done_err),
    .err(err), .level(level), .busy(busy));

  serial_bus_cmd_scheduler #(.TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(cmd_write),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_burst(cmd_burst),
    .flush(flush), .err_clr(err_clr), .trans_done(trans_done), .new_rx(new_rx), .data_in(data_in),
    .instruction(t_instruction), .slave_select(t_slave_select), .address(t_address), .data_out(t_data_out),
    .burst_num(t_burst_num), .rx_valid(t_rx_valid), .rx_data(t_rx_data), .done(t_done), .done_err(t_done_err),
    .err(t_err), .level(t_level), .busy(t_busy));

  // monitor: every issue and every rx byte of the main instance is checked against the scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) prev_instr = 2'b00;
    else begin
      if (instruction != 2'b00 && prev_instr == 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected got %h", {instruction, slave_select, address, data_out, burst_num});
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({instruction, slave_select, address, data_out, burst_num} !== e) begin
            errors++;
            $display("FAIL issue got %h exp %h", {instruction, slave_select, address, data_out, burst_num}, e);
          end
        end
      end
      if (rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got %h", rx_data);
        end else begin
          logic [7:0] r;
          r = rx_q.pop_front();
          if (rx_data !== r) begin
            errors++;
            $display("FAIL rx_data got %h exp %h", rx_data, r);
          end
        end
      end
      if (done) done_cnt++;
      prev_instr = instruction;
    end
  end

  task automatic do_reset;
    reset = 1'b1;
    {cmd_valid, flush, err_clr, trans_done, new_rx} = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    done_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic w, input logic [1:0] s, input logic [11:0] a, input logic [7:0] d,
                          input logic [11:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    {cmd_write, cmd_slave, cmd_addr, cmd_data, cmd_burst} = {w, s, a, d, b};
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL push_wait got ready %b exp 1", cmd_ready);
    end
    exp_q.push_back({w ? 2'b10 : 2'b11, s, a, d, b});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issue;
    int n = 0;
    while (instruction == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_wait got %b exp nonzero", instruction);
    end
  endtask

  task automatic complete(input int cnt, input int dly);
    for (int i = 0; i < cnt; i++) begin
      wait_issue();
      repeat (dly) @(negedge clk);
      trans_done = 1'b1;
      @(negedge clk);
      trans_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({instruction, slave_select, address, data_out, burst_num, rx_data} !== {2'b00, 2'd1, 12'h0, 8'h0, 12'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_outputs got %h", {instruction, slave_select, address, data_out, burst_num, rx_data});
    end
    checks++;
    if ({rx_valid, done, done_err, err, busy, cmd_ready, level} !== {6'b000001, 3'd0}) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000001000", {rx_valid, done, done_err, err, busy, cmd_ready, level});
    end
  endtask

  task automatic test_write;
    do_reset();
    push_cmd(1'b1, 2'd2, 12'h0A5, 8'h3C, 12'd1);
    checks++;
    if (instruction !== 2'b00 || level !== 3'd1) begin
      errors++;
      $display("FAIL wr_pre got instr %b level %0d exp 00 1", instruction, level);
    end
    @(negedge clk);
    checks++;
    if ({instruction, slave_select, address, data_out, busy, level} !== {2'b10, 2'd2, 12'h0A5, 8'h3C, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wr_issue got %h", {instruction, slave_select, address, data_out, busy, level});
    end
    repeat (19) @(negedge clk);
    trans_done = 1'b1;
    @(negedge clk);
    trans_done = 1'b0;
    checks++;
    if ({done, done_err, instruction, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL wr_done got %b exp 10000", {done, done_err, instruction, busy});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL wr_done_pulse got done %b cnt %0d exp 0 1", done, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    push_cmd(1'b1, 2'd0, 12'h100, 8'h01, 12'd1);
    push_cmd(1'b0, 2'd1, 12'h200, 8'h02, 12'd2);
    push_cmd(1'b1, 2'd2, 12'h300, 8'h03, 12'd3);
    push_cmd(1'b0, 2'd3, 12'h400, 8'h04, 12'd4);
    push_cmd(1'b1, 2'd1, 12'h500, 8'h05, 12'd5);
    checks++;
    if (cmd_ready !== 1'b0 || level !== 3'd4 || instruction !== 2'b10) begin
      errors++;
      $display("FAIL b2b_full got ready %b level %0d instr %b exp 0 4 10", cmd_ready, level, instruction);
    end
    fork
      push_cmd(1'b0, 2'd2, 12'h600, 8'h06, 12'd6);
      complete(6, 3);
    join
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 6 || exp_q.size() != 0 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got done %0d pend %0d level %0d busy %b exp 6 0 0 0", done_cnt, exp_q.size(), level, busy);
    end
  endtask

  task automatic test_read;
    logic [7:0] bytes [3];
    bytes = '{8'h11, 8'h22, 8'h33};
    do_reset();
    push_cmd(1'b0, 2'd1, 12'h123, 8'hFF, 12'd3);
    wait_issue();
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      new_rx = 1'b1;
      data_in = bytes[i];
      trans_done = i == 2;
      rx_q.push_back(bytes[i]);
      @(negedge clk);
      {new_rx, trans_done} = 2'b00;
    end
    checks++;
    if ({done, done_err, instruction} !== 4'b1000) begin
      errors++;
      $display("FAIL rd_done got %b exp 1000", {done, done_err, instruction});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rd_end got done %0d rx_pend %0d exp 1 0", done_cnt, rx_q.size());
    end
  endtask

  task automatic test_timeout;
    do_reset();
    push_cmd(1'b0, 2'd3, 12'h0F0, 8'h00, 12'd2);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (t_done !== 1'b0 || t_instruction !== 2'b11) begin
        errors++;
        $display("FAIL to_wait%0d got done %b instr %b exp 0 11", k, t_done, t_instruction);
      end
    end
    @(negedge clk);
    checks++;
    if ({t_done, t_done_err, t_err, t_instruction} !== 5'b11100) begin
      errors++;
      $display("FAIL to_abort got %b exp 11100", {t_done, t_done_err, t_err, t_instruction});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (t_done !== 1'b0 || t_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky got done %b err %b exp 0 1", t_done, t_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (t_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clr got %b exp 0", t_err);
    end
    push_cmd(1'b0, 2'd0, 12'h0F1, 8'h00, 12'd1);
    repeat (16) @(negedge clk);
    trans_done = 1'b1;
    @(negedge clk);
    trans_done = 1'b0;
    checks++;
    if ({t_done, t_done_err, t_err} !== 3'b100) begin
      errors++;
      $display("FAIL to_edge got %b exp 100", {t_done, t_done_err, t_err});
    end
  endtask

  task automatic test_flush;
    do_reset();
    push_cmd(1'b1, 2'd1, 12'h0AA, 8'h5A, 12'd1);
    push_cmd(1'b0, 2'd2, 12'h0BB, 8'h00, 12'd2);
    push_cmd(1'b1, 2'd3, 12'h0CC, 8'h77, 12'd3);
    push_cmd(1'b0, 2'd0, 12'h0DD, 8'h00, 12'd4);
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL fl_level_pre got %0d exp 3", level);
    end
    flush = 1'b1;
    cmd_valid = 1'b1;
    {cmd_write, cmd_slave, cmd_addr, cmd_data, cmd_burst} = {1'b1, 2'd2, 12'hEEE, 8'hEE, 12'd9};
    @(negedge clk);
    {flush, cmd_valid} = 2'b00;
    exp_q.delete();
    checks++;
    if (level !== 3'd0 || instruction !== 2'b10 || address !== 12'h0AA || busy !== 1'b1) begin
      errors++;
      $display("FAIL fl_after got level %0d instr %b addr %h busy %b exp 0 10 0aa 1", level, instruction, address, busy);
    end
    repeat (3) @(negedge clk);
    trans_done = 1'b1;
    @(negedge clk);
    trans_done = 1'b0;
    checks++;
    if ({done, done_err} !== 2'b10) begin
      errors++;
      $display("FAIL fl_done got %b exp 10", {done, done_err});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 1 || instruction !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fl_end got done %0d instr %b busy %b exp 1 00 0", done_cnt, instruction, busy);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    push_cmd(1'b0, 2'd2, 12'h111, 8'h00, 12'd4);
    push_cmd(1'b1, 2'd1, 12'h222, 8'h22, 12'd1);
    push_cmd(1'b0, 2'd0, 12'h333, 8'h00, 12'd2);
    checks++;
    if (instruction !== 2'b11 || level !== 3'd2) begin
      errors++;
      $display("FAIL rm_pre got instr %b level %0d exp 11 2", instruction, level);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({instruction, slave_select, address, data_out, burst_num, level, busy, done, rx_valid, cmd_ready}
        !== {2'b00, 2'd1, 12'h0, 8'h0, 12'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rm_async got %h", {instruction, slave_select, address, data_out, burst_num, level, busy, done, rx_valid, cmd_ready});
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != 0 || level !== 3'd0 || instruction !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_after got done %0d level %0d instr %b busy %b exp 0 0 00 0", done_cnt, level, instruction, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
